// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down counter family.
package counter_pkg;

  localparam int unsigned CNT_WRAP = 0;
  localparam int unsigned CNT_SAT  = 1;

  function automatic logic [31:0] clamp_load(input logic [31:0] val, input logic [31:0] max);
    return (val > max) ? max : val;
  endfunction

  function automatic logic is_boundary(input logic [31:0] cnt, input logic up_dn,
                                       input logic [31:0] max);
    return up_dn ? (cnt == max) : (cnt == '0);
  endfunction

endpackage

// File: rtl/tff_cell.sv
// Single toggle flip-flop with synchronous reset and a forced-value override.
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  input  logic force_en,
  input  logic force_val,
  output logic q,
  output logic qbar
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    if (force_en)
      q_d = force_val;
    else if (t)
      q_d = ~q_q;
  end

  always_ff @(posedge clk) begin
    if (rst)
      q_q <= 1'b0;
    else
      q_q <= q_d;
  end

  assign q    = q_q;
  assign qbar = ~q_q;

endmodule

// File: rtl/sync_updown_counter.sv
// Up/down counter built from toggle cells with carry/borrow enable chains,
// parallel load with clamp, and wrap or saturate at the terminal values.
module sync_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH    = 4,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter int unsigned      SATURATE = CNT_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic [WIDTH-1:0] cntbar,
  output logic             tc,
  output logic             wrap
);

  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] force_en;
  logic [WIDTH-1:0] force_val;
  logic [31:0]      cnt32;
  logic [31:0]      max32;
  logic [31:0]      lv32;
  logic [31:0]      clamped;
  logic             bnd;
  logic             chain;
  logic             wrap_d;
  logic             wrap_q;

  always_comb begin
    cnt32              = '0;
    cnt32[WIDTH-1:0]   = cnt;
    max32              = '0;
    max32[WIDTH-1:0]   = MAX_VAL;
    lv32               = '0;
    lv32[WIDTH-1:0]    = load_val;
    clamped            = clamp_load(lv32, max32);
    bnd                = is_boundary(cnt32, up_dn, max32);
    tc                 = en & ~load & bnd;
    t                  = '0;
    force_en           = '0;
    force_val          = '0;
    wrap_d             = 1'b0;
    chain              = 1'b1;
    if (load) begin
      force_en  = '1;
      force_val = clamped[WIDTH-1:0];
    end else if (en) begin
      if (bnd) begin
        // Boundary values are imposed on every cell, bypassing the chain.
        force_en = '1;
        if (SATURATE == CNT_SAT) begin
          force_val = cnt;
        end else begin
          force_val = up_dn ? '0 : MAX_VAL;
          wrap_d    = 1'b1;
        end
      end else begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
          t[i]  = chain;
          chain = chain & (up_dn ? cnt[i] : ~cnt[i]);
        end
      end
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    tff_cell u_cell (
      .clk      (clk),
      .rst      (rst),
      .t        (t[g]),
      .force_en (force_en[g]),
      .force_val(force_val[g]),
      .q        (cnt[g]),
      .qbar     (cntbar[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst)
      wrap_q <= 1'b0;
    else
      wrap_q <= wrap_d;
  end

  assign wrap = wrap_q;

endmodule

// File: tb/tb_sync_updown_counter.sv
// Scoreboard bench for sync_updown_counter across several parameter sets.
module tb_sync_updown_counter;

  localparam int N = 6;
  localparam int W_A  [N] = '{4, 4, 4, 1, 8, 16};
  localparam int MX_A [N] = '{15, 9, 9, 1, 255, 65535};
  localparam int SAT_A[N] = '{0, 0, 1, 0, 0, 0};

  typedef struct {
    int   idx;
    int   cnt;
    logic wrap;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst, en, up_dn, load;
  logic [15:0] load_val;

  logic [3:0]  c0, c1, c2, b0, b1, b2;
  logic [0:0]  c3, b3;
  logic [7:0]  c4, b4;
  logic [15:0] c5, b5;
  logic [N-1:0] tc_o, wr_o;
  logic [15:0] obs_cnt[N];
  logic [15:0] obs_bar[N];

  int  n_cmp = 0;
  int  n_bad = 0;
  int  m_cnt[N];
  bit  valid = 1'b0;
  int  wrap_cnt0;
  sb_t sb_q[$];

  always #5 clk = ~clk;

  sync_updown_counter #(.WIDTH(4), .MAX_VAL(4'd15), .SATURATE(0)) u0 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val[3:0]),
    .cnt(c0), .cntbar(b0), .tc(tc_o[0]), .wrap(wr_o[0]));
  sync_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(0)) u1 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val[3:0]),
    .cnt(c1), .cntbar(b1), .tc(tc_o[1]), .wrap(wr_o[1]));
  sync_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1)) u2 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val[3:0]),
    .cnt(c2), .cntbar(b2), .tc(tc_o[2]), .wrap(wr_o[2]));
  sync_updown_counter #(.WIDTH(1), .MAX_VAL(1'b1), .SATURATE(0)) u3 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val[0:0]),
    .cnt(c3), .cntbar(b3), .tc(tc_o[3]), .wrap(wr_o[3]));
  sync_updown_counter #(.WIDTH(8), .MAX_VAL(8'hFF), .SATURATE(0)) u4 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val[7:0]),
    .cnt(c4), .cntbar(b4), .tc(tc_o[4]), .wrap(wr_o[4]));
  sync_updown_counter #(.WIDTH(16), .MAX_VAL(16'hFFFF), .SATURATE(0)) u5 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .cnt(c5), .cntbar(b5), .tc(tc_o[5]), .wrap(wr_o[5]));

  assign obs_cnt[0] = 16'(c0);
  assign obs_cnt[1] = 16'(c1);
  assign obs_cnt[2] = 16'(c2);
  assign obs_cnt[3] = 16'(c3);
  assign obs_cnt[4] = 16'(c4);
  assign obs_cnt[5] = c5;
  assign obs_bar[0] = 16'(b0);
  assign obs_bar[1] = 16'(b1);
  assign obs_bar[2] = 16'(b2);
  assign obs_bar[3] = 16'(b3);
  assign obs_bar[4] = 16'(b4);
  assign obs_bar[5] = b5;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one clock: checks tc before the edge, predicts the next state,
  // then compares the DUT against the popped predictions after the edge.
  task automatic step();
    sb_t e;
    int  mask, lv, nc;
    logic nw, etc;
    #1;
    for (int i = 0; i < N; i++) begin
      if (valid) begin
        etc = en & ~load & (up_dn ? (m_cnt[i] == MX_A[i]) : (m_cnt[i] == 0));
        chk($sformatf("tc%0d", i), 32'(tc_o[i]), 32'(etc));
      end
      mask = (1 << W_A[i]) - 1;
      lv   = int'(load_val) & mask;
      nc   = m_cnt[i];
      nw   = 1'b0;
      if (rst) begin
        nc = 0;
      end else if (load) begin
        nc = (lv > MX_A[i]) ? MX_A[i] : lv;
      end else if (en) begin
        if (up_dn) begin
          if (m_cnt[i] < MX_A[i]) nc = m_cnt[i] + 1;
          else if (SAT_A[i] == 0) begin nc = 0; nw = 1'b1; end
        end else begin
          if (m_cnt[i] > 0) nc = m_cnt[i] - 1;
          else if (SAT_A[i] == 0) begin nc = MX_A[i]; nw = 1'b1; end
        end
      end
      m_cnt[i] = nc;
      e.idx = i; e.cnt = nc; e.wrap = nw;
      sb_q.push_back(e);
    end
    if (rst) valid = 1'b1;
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      mask = (1 << W_A[e.idx]) - 1;
      chk($sformatf("cnt%0d", e.idx), 32'(obs_cnt[e.idx]), 32'(e.cnt));
      chk($sformatf("bar%0d", e.idx), 32'(obs_bar[e.idx]), 32'(~e.cnt & mask));
      chk($sformatf("wrap%0d", e.idx), 32'(wr_o[e.idx]), 32'(e.wrap));
      if (e.idx == 0 && wr_o[0]) wrap_cnt0++;
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    rst = 1'b1; en = 1'b1; up_dn = 1'b1; load = 1'b0; load_val = '0;
    repeat (2) step();
    chk("rst_cnt", 32'(c0), 32'd0);
    chk("rst_bar", 32'(b0), 32'hF);
    chk("rst_wrap", 32'(wr_o[0]), 32'd0);

    rst = 1'b0; wrap_cnt0 = 0;
    repeat (20) step();
    chk("wrap_once", 32'(wrap_cnt0), 32'd1);
    chk("cnt_after20", 32'(c0), 32'd4);

    load = 1'b1; load_val = 16'd0; step();
    load = 1'b0;
    repeat (9) step();
    chk("dec_at9", 32'(c1), 32'd9);
    step();
    chk("dec_wrap_up", 32'(wr_o[1]), 32'd1);
    up_dn = 1'b0;
    step();
    chk("dec_down_to9", 32'(c1), 32'd9);
    chk("dec_wrap_dn", 32'(wr_o[1]), 32'd1);

    up_dn = 1'b1; load = 1'b1; load_val = 16'd8; step();
    load = 1'b0;
    repeat (4) step();
    chk("sat_hi", 32'(c2), 32'd9);
    chk("sat_nowrap", 32'(wr_o[2]), 32'd0);
    load = 1'b1; load_val = 16'd1; step();
    load = 1'b0; up_dn = 1'b0;
    repeat (2) step();
    chk("sat_lo", 32'(c2), 32'd0);

    up_dn = 1'b1; en = 1'b0; load = 1'b1; load_val = 16'd12; step();
    chk("clamp", 32'(c1), 32'd9);
    en = 1'b1; load_val = 16'd3; step();
    chk("load_over_en", 32'(c0), 32'd3);
    load = 1'b0; en = 1'b0;
    repeat (5) step();
    chk("hold", 32'(c0), 32'd3);

    load = 1'b1; load_val = 16'd7; step();
    load_val = 16'd5; en = 1'b1; rst = 1'b1; step();
    chk("mid_rst_cnt", 32'(c0), 32'd0);
    chk("mid_rst_wrap", 32'(wr_o[0]), 32'd0);
    rst = 1'b0;

    load_val = 16'hFFF0; step();
    load = 1'b0; up_dn = 1'b1;
    repeat (300) step();
    chk("sweep16", 32'(c5), 32'h011C);
    chk("sweep8", 32'(c4), 32'd28);

    for (int k = 0; k < 200; k++) begin
      rst      = ($urandom_range(0, 49) == 0);
      load     = ($urandom_range(0, 9) == 0);
      en       = ($urandom_range(0, 3) != 0);
      up_dn    = $urandom_range(0, 1) != 0;
      load_val = 16'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
